// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants for the parametrised program counter:
//                mode encodings and default address width / stack depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Mode input encoding.
    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    // Default geometry.
    localparam int PC_AW_DEFAULT    = 4;
    localparam int PC_DEPTH_DEFAULT = 4;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ret_stack
//  Description : DEPTH x AW LIFO holding return addresses. Push/pop are
//                ignored when full/empty respectively; clr empties the stack.
//                The top entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ret_stack #(
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic          full,
    output logic          empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] sp_q;
    logic [PW-1:0] sp_d;
    logic [PW-1:0] sp_m1;

    assign full  = (sp_q == PW'(DEPTH));
    assign empty = (sp_q == '0);
    assign sp_m1 = sp_q - PW'(1);
    assign top_data = mem_q[sp_m1[IW-1:0]];

    // Entry count: clear wins, then guarded push or pop.
    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = '0;
        end else if (push && !full) begin
            sp_d = sp_q + PW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_m1;
        end
    end

    // Stack pointer register; reset discards any stored entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage write at the current free slot.
    always_ff @(posedge clk) begin
        if (!clr && push && !full) begin
            mem_q[sp_q[IW-1:0]] <= push_data;
        end
    end

endmodule : pc_ret_stack
`default_nettype wire

// File: rtl/prog_count_param.sv
`default_nettype none
// ============================================================================
//  Module      : prog_count_param
//  Description : Parametrised program counter for the microcode control unit.
//                Load mode fills instruction memory sequentially on a strobe;
//                run mode executes with stall, jump and (optionally) call/ret.
//                A mode change restarts the counter. done flags end of program
//                or a full load; stk_err flags return-stack faults.
//                Optional feature macro: PC_STACK_EN (return stack, call/ret).
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_count_param
    import pc_pkg::*;
#(
    parameter int AW    = PC_AW_DEFAULT,
    parameter int DEPTH = PC_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          load,
    input  logic          stall,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic          call_en,
    input  logic          ret_en,
    output logic [AW-1:0] pc,
    output logic          done,
    output logic          stk_err
);

    logic [AW-1:0] pc_q,   pc_d;
    logic          done_q, done_d;
    logic          mode_q;
    logic          mode_vld_q;   // mode_q holds a real sample (not first clock)
    logic          restart;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] adv_pc;       // increment with end-of-space stop
    logic          adv_done;

    assign restart  = mode_vld_q && (mode != mode_q);
    assign pc_inc   = pc_q + AW'(1);
    assign adv_pc   = (&pc_q) ? '0 : pc_inc;
    assign adv_done = &pc_q;

`ifdef PC_STACK_EN
    logic          stk_err_q, stk_err_d;
    logic          stk_push, stk_pop, stk_clr;
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty;

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign stk_err = stk_err_q;
`else
    logic unused_ok;
    assign unused_ok = ^{call_en, ret_en, DEPTH};
    assign stk_err   = 1'b0;
`endif

    // Next-state selection in priority order: restart, done, mode-specific.
    always_comb begin
        pc_d   = pc_q;
        done_d = done_q;
`ifdef PC_STACK_EN
        stk_err_d = stk_err_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clr   = 1'b0;
`endif
        if (restart) begin
            pc_d   = '0;
            done_d = 1'b0;
`ifdef PC_STACK_EN
            stk_err_d = 1'b0;
            stk_clr   = 1'b1;
`endif
        end else if (done_q) begin
            pc_d = '0;
        end else if (mode == MODE_RUN) begin
            if (stall) begin
                pc_d = pc_q;
`ifdef PC_STACK_EN
            end else if (ret_en) begin
                if (stk_empty) begin
                    pc_d      = adv_pc;
                    done_d    = adv_done;
                    stk_err_d = 1'b1;
                end else begin
                    pc_d    = stk_top;
                    stk_pop = 1'b1;
                end
            end else if (call_en) begin
                if (stk_full) begin
                    pc_d      = adv_pc;
                    done_d    = adv_done;
                    stk_err_d = 1'b1;
                end else begin
                    pc_d     = jump_addr;
                    stk_push = 1'b1;
                end
`endif
            end else if (jump_en) begin
                pc_d = jump_addr;
            end else begin
                pc_d   = adv_pc;
                done_d = adv_done;
            end
        end else if (mode == MODE_LOAD && load) begin
            pc_d   = adv_pc;
            done_d = adv_done;
        end
    end

    // State registers; mode_q is first captured on the clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            done_q     <= 1'b0;
            mode_q     <= 1'b0;
            mode_vld_q <= 1'b0;
`ifdef PC_STACK_EN
            stk_err_q  <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            done_q     <= done_d;
            mode_q     <= mode;
            mode_vld_q <= 1'b1;
`ifdef PC_STACK_EN
            stk_err_q  <= stk_err_d;
`endif
        end
    end

    assign pc   = pc_q;
    assign done = done_q;

endmodule : prog_count_param
`default_nettype wire

// File: tb/tb_prog_count_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_count_param
//  Description : Self-checking bench for prog_count_param (AW=4, DEPTH=2):
//                directed vector table, hand-written corner sequences and a
//                randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_count_param;

    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int NPC   = 1 << AW;
`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mode, load, stall, jump_en, call_en, ret_en;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] pc;
    logic          done, stk_err;

    int total = 0;
    int bad   = 0;

    prog_count_param #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .load      (load),
        .stall     (stall),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .pc        (pc),
        .done      (done),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic ld, input logic st, input logic je,
                         input logic [AW-1:0] ja, input logic ce, input logic re);
        mode = m; load = ld; stall = st; jump_en = je; jump_addr = ja;
        call_en = ce; ret_en = re;
    endtask

    // One clock, then settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string name, input int epc, input int edone, input int eerr);
        check({name, ".pc"},   int'(pc),      epc);
        check({name, ".done"}, int'(done),    edone);
        check({name, ".err"},  int'(stk_err), eerr);
    endtask

    // ---------------- reference model ----------------
    int m_pc;
    bit m_done, m_err, m_seen, m_prev;
    int m_stk[$];

    function automatic void m_reset();
        m_pc = 0; m_done = 0; m_err = 0; m_seen = 0; m_prev = 0;
        m_stk.delete();
    endfunction

    function automatic void m_adv();
        if (m_pc == NPC - 1) begin
            m_pc = 0; m_done = 1;
        end else begin
            m_pc = m_pc + 1;
        end
    endfunction

    function automatic void m_step(input bit md, input bit ld, input bit st, input bit je,
                                   input int ja, input bit ce, input bit re);
        bit restart;
        restart = m_seen && (md != m_prev);
        m_seen  = 1;
        m_prev  = md;
        if (restart) begin
            m_pc = 0; m_done = 0; m_err = 0; m_stk.delete();
        end else if (m_done) begin
            m_pc = 0;
        end else if (md) begin
            if (st) begin
                // hold
            end else if (STK && re) begin
                if (m_stk.size() == 0) begin m_adv(); m_err = 1; end
                else m_pc = m_stk.pop_back();
            end else if (STK && ce) begin
                if (m_stk.size() == DEPTH) begin m_adv(); m_err = 1; end
                else begin m_stk.push_back((m_pc + 1) % NPC); m_pc = ja; end
            end else if (je) begin
                m_pc = ja;
            end else begin
                m_adv();
            end
        end else if (ld) begin
            m_adv();
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          mode, load, stall, jump_en;
        logic [AW-1:0] ja;
        int            exp_pc;
        logic          exp_done;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        // Starts from: run mode, done=1, pc=0.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  0,  1'b0}; // to load: restart
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1,  1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  2,  1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3,  1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4,  1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  5,  1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  5,  1'b0}; // no strobe: hold
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  0,  1'b0}; // to run: restart wins
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1,  1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  2,  1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3,  1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  3,  1'b0}; // stall beats jump
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd9,  9,  1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  10, 1'b0}; // load ignored in run
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 15, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0,  1'b1}; // end of space
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  0,  1'b1}; // done blocks jump
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  0,  1'b0}; // restart
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  1,  1'b0}; // load ignores jump/stall
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #12;
        check3("reset", 0, 0, 0);
        rst = 1'b0;

        // Free run to end of program, then hold.
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("run.pc", int'(pc), (i == 16) ? 0 : i);
            check("run.done", int'(done), (i == 16) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check3("done_hold", 0, 1, 0);
        end

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].mode, tbl[i].load, tbl[i].stall, tbl[i].jump_en, tbl[i].ja, 1'b0, 1'b0);
            tick();
            check($sformatf("vec%0d.pc", i), int'(pc), tbl[i].exp_pc);
            check($sformatf("vec%0d.done", i), int'(done), int'(tbl[i].exp_done));
        end

        // Load fill to the top of the address space: done set, pc back to 0.
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check3("load_full", 0, 1, 0);
        tick();
        check3("load_full_hold", 0, 1, 0);

        // Back to run mode: restart.
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        check3("restart_run", 0, 0, 0);

`ifdef PC_STACK_EN
        // Nested call / return: 8, 12, 10, 3.
        tick(); tick();
        check3("pre_call", 2, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);  // call beats jump
        tick(); check3("call1", 8, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(); check3("inc9", 9, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0);
        tick(); check3("call2", 12, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);   // ret beats call
        tick(); check3("ret1", 10, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick(); check3("ret2", 3, 0, 0);

        // Overflow then underflow; error sticky until mode toggle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        tick(); check3("ovf_c1", 5, 0, 0);
        tick(); check3("ovf_c2", 5, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
        tick(); check3("ovf_c3", 6, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick(); check3("ovf_r1", 6, 0, 1);
        tick(); check3("ovf_r2", 4, 0, 1);
        tick(); check3("unf_r3", 5, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(); check3("err_sticky", 6, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(); check3("err_clear", 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick(); check3("err_clr_run", 0, 0, 0);      // restart ignores ret
        tick(); check3("err_set_again", 1, 0, 1);     // empty stack
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick(); check3("jmp0", 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick(); check3("call6", 6, 0, 1);
`else
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1); // call/ret ignored
        tick(); check3("nostk_jmp", 6, 0, 0);
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(); check3("at7", 7, 0, STK ? 1 : 0);

        // Asynchronous reset away from any clock edge.
        #3 rst = 1'b1;
        #1 check3("async_rst", 0, 0, 0);
        #2 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        check3("post_rst_ret", 1, 0, STK ? 1 : 0);

        // Randomized run against the reference model.
        rst = 1'b1;
        #2 rst = 1'b0;
        m_reset();
        begin
            bit md = 1'b1;
            for (int i = 0; i < 600; i++) begin
                bit ld, st, je, ce, re;
                int ja;
                if ($urandom_range(0, 99) < 4) md = ~md;
                ld = ($urandom_range(0, 99) < 60);
                st = ($urandom_range(0, 99) < 15);
                je = ($urandom_range(0, 99) < 15);
                ce = ($urandom_range(0, 99) < 15);
                re = ($urandom_range(0, 99) < 15);
                ja = $urandom_range(0, NPC - 1);
                drive(md, ld, st, je, AW'(ja), ce, re);
                m_step(md, ld, st, je, ja, ce, re);
                tick();
                check3($sformatf("rnd%0d", i), m_pc, int'(m_done), int'(m_err));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prog_count_param
`default_nettype wire
